// File: rtl/corr_pkg.sv
// Shared definitions for the gated photon-pulse counter.
// Contents: default sizing constants, the FIFO entry layout and the gate FSM state type.
package corr_pkg;

  localparam int unsigned DEF_CNT_W      = 12;
  localparam int unsigned DEF_GATE_CYC   = 84317;
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned DEF_DROP_W     = 8;

  // One closed window as stored in the readout FIFO (default count width)
  typedef struct packed {
    logic                 sat;
    logic [DEF_CNT_W-1:0] count;
  } corr_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } corr_state_e;

endpackage

// File: rtl/corr_gate_counter_if.sv
// Readout handshake bundle between the gate counter (master) and its consumer (slave).
//   cnt_data  : FIFO head count (0 when empty)
//   cnt_sat   : FIFO head saturation flag
//   cnt_valid : FIFO non-empty
//   cnt_ready : consumer accepts the head entry
interface corr_gate_counter_if
  import corr_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic [CNT_W-1:0] cnt_data;
  logic             cnt_sat;
  logic             cnt_valid;
  logic             cnt_ready;

  modport master (output cnt_data, output cnt_sat, output cnt_valid, input cnt_ready);
  modport slave  (input cnt_data, input cnt_sat, input cnt_valid, output cnt_ready);

endinterface

// File: rtl/corr_fifo.sv
// Show-ahead FIFO holding closed-window results.
//   clk, rst     : clock, synchronous active-high reset (flushes contents)
//   i_push/i_data: write request and entry
//   i_pop        : remove head (ignored when empty)
//   o_head       : current head entry (show-ahead)
//   o_full/o_empty/o_level : occupancy status
//   o_push_acc   : push was written this cycle
module corr_fifo
  import corr_pkg::*;
#(
  parameter int unsigned W     = DEF_CNT_W + 1,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_push_acc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [LVL_W-1:0] r_level;
  logic             w_pop;

  assign o_empty    = (r_level == '0);
  assign o_full     = (r_level == LVL_W'(DEPTH));
  assign o_level    = r_level;
  assign o_head     = r_mem[r_rd];
  assign w_pop      = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign o_push_acc = i_push & (~o_full | w_pop);

  // Storage array, no reset needed: occupancy gates visibility
  always_ff @(posedge clk) begin
    if (o_push_acc) r_mem[r_wr] <= i_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (o_push_acc) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)      r_rd <= r_rd + PTR_W'(1);
      case ({o_push_acc, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/corr_gate_counter.sv
// Gated photon-pulse counter: synchronises data_in, counts rising edges over
// GATE_CYC-cycle windows (saturating), queues each closed window for readout.
//   clki, rst  : clock, synchronous active-high reset
//   data_in    : asynchronous pulse input
//   gate_enb   : 1 = run windows, 0 = idle and discard the partial window
//   rd         : readout handshake (cnt_data/cnt_sat/cnt_valid out, cnt_ready in)
//   fifo_level : readout FIFO occupancy
//   drop_cnt   : saturating count of windows lost to a full FIFO
module corr_gate_counter
  import corr_pkg::*;
#(
  parameter int unsigned GATE_CYC   = DEF_GATE_CYC,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned DROP_W     = DEF_DROP_W
) (
  input  logic                          clki,
  input  logic                          rst,
  input  logic                          data_in,
  input  logic                          gate_enb,
  corr_gate_counter_if.master           rd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]             drop_cnt
);

  localparam int unsigned TMR_W = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam int unsigned ENT_W = CNT_W + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic              r_s1, r_s2, r_s3;
  corr_state_e       r_state;
  logic [TMR_W-1:0]  r_timer;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sat;
  logic [DROP_W-1:0] r_drop;

  logic              w_edge;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_sat_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_push_acc;
  logic              w_full;
  logic              w_empty;
  logic [ENT_W-1:0]  w_head;

  // Window bookkeeping including the edge of the current cycle
  always_comb begin
    w_edge    = r_s2 & ~r_s3;
    w_cnt_nxt = r_cnt;
    w_sat_nxt = r_sat;
    if (w_edge) begin
      if (r_cnt == CNT_MAX) w_sat_nxt = 1'b1;  // edge lost to saturation
      else                  w_cnt_nxt = r_cnt + CNT_W'(1);
    end
    // gate_enb low wins over a coinciding window end: the window is discarded
    w_push = (r_state == COUNT) & gate_enb & (r_timer == TMR_LAST);
  end

  assign w_pop = rd.cnt_valid & rd.cnt_ready;

  // Synchroniser, gate FSM, window counter and drop counter
  always_ff @(posedge clki) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_state <= IDLE;
      r_timer <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_s1 <= data_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      if (w_push & w_full & ~w_push_acc & (r_drop != DROP_MAX))
        r_drop <= r_drop + DROP_W'(1);

      case (r_state)
        IDLE: begin
          r_timer <= '0;
          r_cnt   <= '0;
          r_sat   <= 1'b0;
          if (gate_enb) r_state <= COUNT;
        end
        COUNT: begin
          if (!gate_enb || (r_timer == TMR_LAST)) begin
            r_timer <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            if (!gate_enb) r_state <= IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
            r_cnt   <= w_cnt_nxt;
            r_sat   <= w_sat_nxt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  corr_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clki),
    .rst        (rst),
    .i_push     (w_push),
    .i_data     ({w_sat_nxt, w_cnt_nxt}),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_level    (fifo_level),
    .o_push_acc (w_push_acc)
  );

  // Head is forced to zero while nothing is queued
  assign rd.cnt_valid = ~w_empty;
  assign rd.cnt_sat   = w_empty ? 1'b0 : w_head[CNT_W];
  assign rd.cnt_data  = w_empty ? '0 : w_head[CNT_W-1:0];
  assign drop_cnt     = r_drop;

endmodule

// File: tb/tb_corr_gate_counter.sv
// Randomised bench for corr_gate_counter against a window/queue reference model.
module tb_corr_gate_counter;

  localparam int GATE  = 16;
  localparam int CW    = 3;
  localparam int DEPTH = 4;
  localparam int DW    = 3;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int DMAX  = (1 << DW) - 1;

  logic                   clki = 1'b0;
  logic                   rst;
  logic                   data_in;
  logic                   gate_enb;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [DW-1:0]          drop_cnt;

  corr_gate_counter_if #(.CNT_W(CW)) rd_if ();

  corr_gate_counter #(
    .GATE_CYC   (GATE),
    .CNT_W      (CW),
    .FIFO_DEPTH (DEPTH),
    .DROP_W     (DW)
  ) dut (
    .clki       (clki),
    .rst        (rst),
    .data_in    (data_in),
    .gate_enb   (gate_enb),
    .rd         (rd_if),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  always #5 clki = ~clki;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int q[$];
  int m_drop;
  bit m_active;
  int m_pos;
  int m_edges;
  bit h1, h2, h3;  // data_in as sampled 1, 2 and 3 cycles ago

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of behaviour: raw edge count per window, clamp at push time
  task automatic model_step(input bit r, input bit g, input bit d, input bit rdy);
    bit e;
    bit push;
    int ent;
    if (r) begin
      q.delete();
      m_drop = 0; m_active = 0; m_pos = 0; m_edges = 0;
      h1 = 0; h2 = 0; h3 = 0;
      return;
    end
    e  = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = d;
    push = 0;
    ent  = 0;
    if (!m_active) begin
      if (g) begin
        m_active = 1; m_pos = 0; m_edges = 0;
      end
    end else if (!g) begin
      m_active = 0;
    end else begin
      m_edges += int'(e);
      if (m_pos == GATE - 1) begin
        push = 1;
        ent  = (m_edges > CMAX) ? ((1 << CW) | CMAX) : m_edges;
        m_pos = 0;
        m_edges = 0;
      end else begin
        m_pos++;
      end
    end
    if (q.size() != 0 && rdy) q.delete(0);
    if (push) begin
      if (q.size() < DEPTH) q.push_back(ent);
      else if (m_drop < DMAX) m_drop++;
    end
  endtask

  task automatic tick(input bit r, input bit g, input bit d, input bit rdy);
    logic [31:0] exp_head;
    rst = r; gate_enb = g; data_in = d; rd_if.cnt_ready = rdy;
    @(posedge clki);
    #1;
    model_step(r, g, d, rdy);
    exp_head = (q.size() != 0) ? 32'(q[0]) : 32'd0;
    check_eq("cnt_valid",  32'(rd_if.cnt_valid), 32'(q.size() != 0));
    check_eq("head",       32'({rd_if.cnt_sat, rd_if.cnt_data}), exp_head);
    check_eq("fifo_level", 32'(fifo_level), 32'(q.size()));
    check_eq("drop_cnt",   32'(drop_cnt), 32'(m_drop));
  endtask

  initial begin
    rst = 1'b1; gate_enb = 1'b0; data_in = 1'b0; rd_if.cnt_ready = 1'b1;

    repeat (3) tick(1, 0, 0, 1);

    // sparse pulses, consumer always ready
    for (int i = 0; i < 10 * GATE; i++) tick(0, 1, $urandom_range(0, 3) == 0, 1);

    // 1/0 toggle: every window overflows the 3-bit count
    for (int i = 0; i < 3 * GATE; i++) tick(0, 1, (i % 2) == 0, 1);

    // consumer stalled: fill, drop, then drop counter saturates
    for (int i = 0; i < 14 * GATE; i++) tick(0, 1, $urandom_range(0, 1) == 1, 0);
    for (int i = 0; i < 2 * GATE; i++)  tick(0, 1, $urandom_range(0, 2) == 0, 1);

    // fresh start, then random gate drops and back-pressure
    tick(1, 0, 0, 1);
    for (int i = 0; i < 4000; i++)
      tick(0, $urandom_range(0, 63) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);

    // reset mid-window with entries queued
    for (int i = 0; i < 2 * GATE + 7; i++) tick(0, 1, $urandom_range(0, 1) == 1, 0);
    tick(1, 1, 0, 0);
    for (int i = 0; i < 3 * GATE; i++) tick(0, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
